// File: rtl/key_pkg.sv
// key_pkg: shared constants for the push-button front end.
//   - Key index constants (bit positions in the key vectors).
//   - Default timing constants used as parameter defaults.
//   - calc_div(): clock cycles per sampling tick.
package key_pkg;

  localparam int KEY_ADD  = 0;
  localparam int KEY_SUB  = 1;
  localparam int KEY_STOP = 2;
  localparam int KEY_MODE = 3;

  localparam int DEF_CLK_HZ             = 50_000_000;
  localparam int DEF_TICK_MS            = 5;
  localparam int DEF_NUM_KEYS           = 4;
  localparam int DEF_REPEAT_DELAY_TICKS = 100;
  localparam int DEF_REPEAT_RATE_TICKS  = 20;

  // Divide down to kHz first so the product stays inside 32 bits.
  function automatic int calc_div(input int clk_hz, input int tick_ms);
    return (clk_hz / 1000) * tick_ms;
  endfunction

endpackage

// File: rtl/key_filter.sv
// key_filter: conditioning for a single push-button.
//   Two-flop synchroniser, 3-sample window advanced on the shared tick,
//   debounced level register and registered one-cycle press pulse.
//   Optional auto-repeat counter when KEY_REPEAT_EN is defined.
// Ports:
//   clk       in   system clock
//   res       in   asynchronous active-high reset
//   tick      in   one-cycle sampling strobe from the shared divider
//   key_in    in   raw pin, active-low, asynchronous
//   key_level out  debounced level, active-low
//   key_press out  one-cycle pulse on each accepted press (and repeat)
// Configuration macro: KEY_REPEAT_EN (adds REPEAT_DELAY_TICKS / REPEAT_RATE_TICKS).
module key_filter
  import key_pkg::*;
`ifdef KEY_REPEAT_EN
#(
  parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
  parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS
)
`endif
(
  input  logic clk,
  input  logic res,
  input  logic tick,
  input  logic key_in,
  output logic key_level,
  output logic key_press
);

  logic       sync_meta;
  logic       sync_out;
  logic [2:0] window;
  logic       tick_d;
  logic       press_evt;
  logic       release_evt;

  // Two-flop synchroniser; only the second flop feeds the filter.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync_meta <= 1'b1;
      sync_out  <= 1'b1;
    end else begin
      sync_meta <= key_in;
      sync_out  <= sync_meta;
    end
  end

  // Sample window, newest sample at bit 0, advanced once per tick.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      window <= 3'b111;
    end else if (tick) begin
      window <= {window[1:0], sync_out};
    end
  end

  // The level decision is taken one cycle after the tick so that it sees
  // the window including the sample just shifted in.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      tick_d <= 1'b0;
    end else begin
      tick_d <= tick;
    end
  end

  assign press_evt   = tick_d && (window == 3'b000) && key_level;
  assign release_evt = tick_d && (window == 3'b111) && !key_level;

  // Debounced level: only a unanimous window that disagrees moves it.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      key_level <= 1'b1;
    end else if (press_evt) begin
      key_level <= 1'b0;
    end else if (release_evt) begin
      key_level <= 1'b1;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY_TICKS + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_fire;

  // Fire on the tick that would bring the held count to the delay value.
  // A repeat needs key_level=0 while a new press needs key_level=1, so the
  // two can never coincide.
  assign rpt_fire = tick && !key_level &&
                    (rpt_cnt == RPT_W'(REPEAT_DELAY_TICKS - 1));

  // Held-tick counter: cleared while released and on the press cycle,
  // reloaded after each repeat so later repeats come at the faster rate.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rpt_cnt <= '0;
    end else if (press_evt || key_level) begin
      rpt_cnt <= '0;
    end else if (rpt_fire) begin
      rpt_cnt <= RPT_W'(REPEAT_DELAY_TICKS - REPEAT_RATE_TICKS);
    end else if (tick) begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end

  // Press pulse is registered alongside the level so it marks exactly the
  // first cycle of the low level.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      key_press <= 1'b0;
    end else begin
      key_press <= press_evt || rpt_fire;
    end
  end
`else
  // Press pulse is registered alongside the level so it marks exactly the
  // first cycle of the low level.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      key_press <= 1'b0;
    end else begin
      key_press <= press_evt;
    end
  end
`endif

endmodule

// File: rtl/key_debounce.sv
// key_debounce: push-button front end for the clock board.
//   Shared tick divider plus one key_filter per key.
// Ports:
//   clk       in   system clock
//   res       in   asynchronous active-high reset
//   key_in    in   [NUM_KEYS] raw pins, active-low, {mode, stop, sub, add}
//   key_level out  [NUM_KEYS] debounced levels, active-low
//   key_press out  [NUM_KEYS] one-cycle press pulses, active-high
//   tick      out  one-cycle sampling strobe, every CLK_HZ/1000*TICK_MS cycles
// Configuration macro: KEY_REPEAT_EN enables per-key auto-repeat and the
//   REPEAT_DELAY_TICKS / REPEAT_RATE_TICKS parameters.
module key_debounce
  import key_pkg::*;
#(
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int TICK_MS  = DEF_TICK_MS,
  parameter int NUM_KEYS = DEF_NUM_KEYS
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
  parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS
`endif
) (
  input  logic                clk,
  input  logic                res,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                tick
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_MS);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // Free-running divider 0..DIV-1 shared by all keys.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_filter
`ifdef KEY_REPEAT_EN
    #(
      .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
      .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS)
    )
`endif
    u_filter (
      .clk      (clk),
      .res      (res),
      .tick     (tick),
      .key_in   (key_in[i]),
      .key_level(key_level[i]),
      .key_press(key_press[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: randomized, scoreboard-checked bench for key_debounce.
//   Runs with a scaled clock (2 kHz, 10 cycles per tick) so ms-scale
//   scenarios stay short. A reference model reasons in samples taken at
//   each tick and schedules expected levels and press pulses; a separate
//   monitor pops expected pulses whenever the DUT shows one.
// Honours KEY_REPEAT_EN in the same way as the design.
module tb_key_debounce;
  import key_pkg::*;

  localparam int TB_CLK_HZ  = 2000;
  localparam int TB_TICK_MS = 5;
  localparam int NK         = 4;
  localparam int T          = (TB_CLK_HZ / 1000) * TB_TICK_MS;
  localparam int CYC_PER_MS = TB_CLK_HZ / 1000;
`ifdef KEY_REPEAT_EN
  localparam int RPT_DELAY  = 100;
  localparam int RPT_RATE   = 20;
`endif

  logic          clk;
  logic          res;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic          tick;

  int compared   = 0;
  int mismatched = 0;

  key_debounce #(
    .CLK_HZ  (TB_CLK_HZ),
    .TICK_MS (TB_TICK_MS),
    .NUM_KEYS(NK)
  ) dut (
    .clk      (clk),
    .res      (res),
    .key_in   (key_in),
    .key_level(key_level),
    .key_press(key_press),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NK-1:0] mask;
  } ev_t;

  ev_t exp_q[$];

  // Insert an expected pulse in cycle order, merging pulses due together.
  function automatic void push_exp(input int c, input logic [NK-1:0] m);
    int  pos;
    ev_t e;
    pos = exp_q.size();
    for (int j = 0; j < exp_q.size(); j++) begin
      if (exp_q[j].cyc == c) begin
        exp_q[j].mask = exp_q[j].mask | m;
        return;
      end
      if (exp_q[j].cyc > c) begin
        pos = j;
        break;
      end
    end
    e.cyc  = c;
    e.mask = m;
    exp_q.insert(pos, e);
  endfunction

  task automatic check_output(input string name, input int cyc_v,
                              input logic [NK-1:0] got, input logic [NK-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: cycle %0d got %b expected %b", name, cyc_v, got, exp);
    end
  endtask

  // Reference model. Cycle c counts clock edges since reset release. The
  // pin value present at edge c+1 reaches the filter as the sample of the
  // tick whose window update lands at edge c+3; a decision becomes visible
  // one edge after that. Three equal consecutive samples differing from the
  // accepted level change it.
  int            cyc;
  logic [NK-1:0] acc_level;
  logic [NK-1:0] vis_level;
  logic          run_val [NK];
  int            run_len [NK];
  int            lvl_at  [NK];
  logic          lvl_val [NK];
  int            held    [NK];

  always @(negedge clk) begin
    if (res) begin
      cyc       = -1;
      acc_level = '1;
      vis_level = '1;
      for (int i = 0; i < NK; i++) begin
        run_val[i] = 1'b1;
        run_len[i] = 3;
        lvl_at[i]  = -1;
        lvl_val[i] = 1'b1;
        held[i]    = 0;
      end
      exp_q.delete();
    end else begin
      cyc++;
      for (int i = 0; i < NK; i++) begin
        if (lvl_at[i] == cyc) begin
          vis_level[i] = lvl_val[i];
          lvl_at[i]    = -1;
        end
      end
      check_output("key_level", cyc, key_level, vis_level);
      check_output("tick", cyc, NK'(tick), NK'((cyc % T) == (T - 1)));
`ifdef KEY_REPEAT_EN
      for (int i = 0; i < NK; i++) begin
        if (vis_level[i]) begin
          held[i] = 0;
        end else if ((cyc % T) == (T - 1)) begin
          held[i]++;
          if (held[i] == RPT_DELAY) begin
            logic [NK-1:0] m;
            m    = '0;
            m[i] = 1'b1;
            push_exp(cyc + 1, m);
            held[i] = RPT_DELAY - RPT_RATE;
          end
        end
      end
`endif
      if (((cyc + 3) % T) == 0 && (cyc + 3) >= T) begin
        for (int i = 0; i < NK; i++) begin
          if (key_in[i] == run_val[i]) begin
            run_len[i]++;
          end else begin
            run_val[i] = key_in[i];
            run_len[i] = 1;
          end
          if (run_len[i] >= 3 && run_val[i] != acc_level[i]) begin
            acc_level[i] = run_val[i];
            lvl_at[i]    = cyc + 4;
            lvl_val[i]   = run_val[i];
            if (!run_val[i]) begin
              logic [NK-1:0] m;
              m    = '0;
              m[i] = 1'b1;
              push_exp(cyc + 4, m);
            end
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a pulse is shown or one is due.
  int mon_cyc;

  always @(negedge clk) begin
    if (res) begin
      mon_cyc = -1;
    end else begin
      mon_cyc++;
      while (exp_q.size() > 0 && exp_q[0].cyc < mon_cyc) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL key_press_missing: cycle %0d got none expected %b",
                 exp_q[0].cyc, exp_q[0].mask);
        void'(exp_q.pop_front());
      end
      if (key_press != '0) begin
        compared++;
        if (exp_q.size() == 0 || exp_q[0].cyc != mon_cyc || exp_q[0].mask != key_press) begin
          mismatched++;
          if (exp_q.size() == 0)
            $display("[TB] FAIL key_press: cycle %0d got %b expected no pulse", mon_cyc, key_press);
          else
            $display("[TB] FAIL key_press: cycle %0d got %b expected %b at cycle %0d",
                     mon_cyc, key_press, exp_q[0].mask, exp_q[0].cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == mon_cyc) void'(exp_q.pop_front());
      end else if (exp_q.size() > 0 && exp_q[0].cyc == mon_cyc) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL key_press_missing: cycle %0d got 0000 expected %b",
                 mon_cyc, exp_q[0].mask);
        void'(exp_q.pop_front());
      end
    end
  end

  // Drive a key pattern (active-low) and hold it for n cycles; always
  // entered and left just after a rising edge.
  task automatic apply_stimulus(input logic [NK-1:0] keys, input int n);
    key_in = keys;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [NK-1:0] low_mask(input int idx);
    logic [NK-1:0] m;
    m      = '1;
    m[idx] = 1'b0;
    return m;
  endfunction

  initial begin
    logic [NK-1:0] add_low;
    logic [NK-1:0] stop_low;
    logic [NK-1:0] sub_mode_low;

    add_low      = low_mask(KEY_ADD);
    stop_low     = low_mask(KEY_STOP);
    sub_mode_low = low_mask(KEY_SUB) & low_mask(KEY_MODE);

    res    = 1'b1;
    key_in = '1;
    repeat (3) @(posedge clk);
    #1;
    res = 1'b0;

    $display("[TB] idle after reset");
    apply_stimulus('1, 4 * T);

    $display("[TB] add held 20 ms");
    apply_stimulus(add_low, 20 * CYC_PER_MS);
    apply_stimulus('1, 4 * T);

    $display("[TB] stop glitch then bounce");
    apply_stimulus(stop_low, 6 * CYC_PER_MS);
    for (int b = 0; b < 10; b++) begin
      apply_stimulus((b % 2 == 0) ? '1 : stop_low, CYC_PER_MS);
    end
    apply_stimulus(stop_low, 5 * T);
    apply_stimulus('1, 4 * T);

    $display("[TB] sub and mode together");
    apply_stimulus(sub_mode_low, 5 * T);
    apply_stimulus('1, 4 * T);

    $display("[TB] random key activity");
    for (int r = 0; r < 80; r++) begin
      apply_stimulus(NK'($urandom), $urandom_range(1, 4 * T));
    end
    apply_stimulus('1, 5 * T);

    $display("[TB] add held 1 s");
    apply_stimulus(add_low, 1000 * CYC_PER_MS);
    apply_stimulus('1, 5 * T);

    $display("[TB] reset while add held");
    apply_stimulus(add_low, 5 * T);
    #1 res = 1'b1;
    #1;
    check_output("reset_key_level", -1, key_level, '1);
    check_output("reset_key_press", -1, key_press, '0);
    check_output("reset_tick", -1, NK'(tick), '0);
    repeat (3) @(posedge clk);
    #1;
    res = 1'b0;
    apply_stimulus(add_low, 6 * T);
    apply_stimulus('1, 5 * T);

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Front-end conditioning stage for the clock board's push-buttons (add, sub, stop, mode). Synchronises raw active-low key inputs into the `clk` domain and filters them with a 5 ms sampling tick and a 3-sample agreement window. Emits a clean debounced level plus a single-`clk`-cycle press pulse per key. Its outputs feed directly into the time-keeping/display block in place of raw pin levels.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz.
- `TICK_MS`, 5, sampling period in ms.
- `NUM_KEYS`, 4, number of keys; bit order {mode, stop, sub, add}, add = bit 0.
- `REPEAT_DELAY_TICKS`, 100, held-key ticks before first auto-repeat (500 ms).
- `REPEAT_RATE_TICKS`, 20, ticks between subsequent auto-repeats (100 ms).
- `clk  in  1`  system clock, 50 MHz.
- `res  in  1`  reset, asynchronous, active-high.
- `key_in  in  NUM_KEYS`  raw pins, active-low (0 = pressed), asynchronous.
- `key_level  out  NUM_KEYS`  debounced level, active-low.
- `key_press  out  NUM_KEYS`  one-`clk` pulse, active-high, on each accepted press (and repeat, if enabled).
- `tick  out  1`  one-`clk` sampling strobe, exported for other slow logic.

## Operation
- Reset values: sync flops all 1; sample windows all 1; `key_level` all 1; `key_press` 0; `tick` 0; divider 0; repeat counters 0.
- Synchroniser: 2 flops per key on `clk`; filter uses the second flop only.
- Divider: `DIV = CLK_HZ/1000*TICK_MS`, counts 0..DIV-1, wraps to 0; `tick` = 1 in the cycle the count equals DIV-1.
- Window: on each `tick`, per key, shift the synchronised bit into a 3-bit register (newest at bit 0).
- Level update: on the `clk` edge following a `tick` where all three window bits are equal and differ from `key_level`, `key_level` takes that value. Mixed windows hold the level.
- Press: `key_press[i]` = 1 for exactly the cycle in which `key_level[i]` transitions 1->0. Release (0->1) produces no pulse.
- Keys are fully independent; simultaneous presses give simultaneous pulses.
- Glitch rejection: any input pulse shorter than 2 ticks (10 ms) never changes `key_level`.
- Reset mid-operation: all state returns to reset values immediately; a key held through reset release produces a press 3 ticks after reset release.

## Timing
- Press latency from a clean stable edge on `key_in`: 2 `clk` (sync) + 3 ticks worst case, 2 ticks + 1 `clk` best case; never above 15 ms + 3 cycles at defaults.
- `key_press` is registered; it never lasts more than 1 cycle.
- Divider width = `$clog2(DIV)`; repeat counter width = `$clog2(REPEAT_DELAY_TICKS+1)`.

## Configuration
- `KEY_REPEAT_EN` defined: per-key repeat counter, cleared on the press cycle, increments on each `tick` while `key_level[i]`=0. On reaching `REPEAT_DELAY_TICKS` it emits a `key_press[i]` pulse and reloads to `REPEAT_DELAY_TICKS-REPEAT_RATE_TICKS`. Release clears the counter. A repeat pulse and a new press cannot coincide.
- Not defined: counters absent; exactly one pulse per press regardless of hold time.

## Structure
- Package `key_pkg`: key index constants (`KEY_ADD=0`, `KEY_SUB=1`, `KEY_STOP=2`, `KEY_MODE=3`), default timing constants, `DIV` computation function.
- Sub-module `key_filter`: one key's sync, window, level, press and optional repeat logic. Instantiated `NUM_KEYS` times via generate. Shared divider stays in the top.

## Test plan
- Reset with all keys released -> `key_level`=4'hF, `key_press`=0, `tick` first high at cycle DIV-1 after reset release.
- Hold add low 20 ms -> exactly one `key_press[0]` pulse within 15 ms of the edge; `key_level[0]`=0; no pulse on release.
- 6 ms low glitch on stop, then 10 ms of bounce toggling every 1 ms -> no pulse until stable low for 3 ticks, then one pulse.
- sub and mode pressed on the same cycle -> `key_press` = 4'b1010 in a single cycle.
- `KEY_REPEAT_EN` defined, add held 1 s -> pulses at ~0 ms, 500 ms, 600 ms … 1000 ms (7 total); without the macro -> 1 pulse.
- `res` asserted while add is held -> outputs reset immediately; after release with add still held -> one press 3 ticks later.
